// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Port 0 is the CPU core, port 1 the debug/program loader.
package mem_arbiter_pkg;

   localparam int BUS_W  = 32;
   localparam int MASK_W = BUS_W / 8;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RDATA  = 2'd2
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   // Round-robin pick; only meaningful when at least one slot is pending.
   function automatic logic pick_port(input logic pend0, input logic pend1,
                                      input logic last_grant);
      return (pend0 && pend1) ? ~last_grant : pend1;
   endfunction

endpackage

// File: rtl/arb_req_slot.sv
// One-deep request slot: captures a strobe-style request when the port is idle
// and holds it, with registered busy flags, until the arbiter clears it.
module arb_req_slot
   import mem_arbiter_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BUS_W-1:0]  addr_i,
   input  logic [BUS_W-1:0]  wdata_i,
   input  logic [MASK_W-1:0] wmask_i,
   input  logic              rstrb_i,
   input  logic              clear_i,
   output logic              pending_o,
   output logic              is_read_o,
   output logic              oor_o,
   output logic [AW-1:0]     addr_o,
   output logic [BUS_W-1:0]  wdata_o,
   output logic [MASK_W-1:0] wmask_o,
   output logic              rbusy_o,
   output logic              wbusy_o
);

   logic              rbusy_q;
   logic              wbusy_q;
   logic              oor_q;
   logic [AW-1:0]     addr_q;
   logic [BUS_W-1:0]  wdata_q;
   logic [MASK_W-1:0] wmask_q;
   logic              busy;
   logic              accept;
   logic              unused_lsb;

   assign unused_lsb = ^addr_i[1:0];
   assign busy       = rbusy_q | wbusy_q;
   assign accept     = (rstrb_i | (|wmask_i)) & ~busy;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rbusy_q <= 1'b0;
         wbusy_q <= 1'b0;
         oor_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else if (clear_i) begin
         rbusy_q <= 1'b0;
         wbusy_q <= 1'b0;
      end else if (accept) begin
         // A nonzero mask wins over a simultaneous read strobe.
         rbusy_q <= (wmask_i == '0);
         wbusy_q <= (wmask_i != '0);
         oor_q   <= ((addr_i >> (AW + 2)) != '0);
         addr_q  <= addr_i[AW+1:2];
         wdata_q <= wdata_i;
         wmask_q <= wmask_i;
      end
   end

   assign pending_o = busy;
   assign is_read_o = rbusy_q;
   assign oor_o     = oor_q;
   assign addr_o    = addr_q;
   assign wdata_o   = wdata_q;
   assign wmask_o   = wmask_q;
   assign rbusy_o   = rbusy_q;
   assign wbusy_o   = wbusy_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency single-port word RAM between
// the CPU core (port 0) and the debug loader (port 1).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BUS_W-1:0]  p0_addr,
   input  logic [BUS_W-1:0]  p0_wdata,
   input  logic [MASK_W-1:0] p0_wmask,
   input  logic              p0_rstrb,
   output logic [BUS_W-1:0]  p0_rdata,
   output logic              p0_rvalid,
   output logic              p0_rbusy,
   output logic              p0_wbusy,
   input  logic [BUS_W-1:0]  p1_addr,
   input  logic [BUS_W-1:0]  p1_wdata,
   input  logic [MASK_W-1:0] p1_wmask,
   input  logic              p1_rstrb,
   output logic [BUS_W-1:0]  p1_rdata,
   output logic              p1_rvalid,
   output logic              p1_rbusy,
   output logic              p1_wbusy,
   output logic              ram_en,
   output logic [MASK_W-1:0] ram_we,
   output logic [AW-1:0]     ram_addr,
   output logic [BUS_W-1:0]  ram_wdata,
   input  logic [BUS_W-1:0]  ram_rdata
);

   logic [1:0]        pend;
   logic [1:0]        is_rd;
   logic [1:0]        oor;
   logic [1:0]        clear;
   logic [AW-1:0]     s_addr  [2];
   logic [BUS_W-1:0]  s_wdata [2];
   logic [MASK_W-1:0] s_wmask [2];
   logic              grant_pick;

   arb_req_slot #(.AW(AW)) u_slot_cpu (
      .clk       (clk),
      .rst       (rst),
      .addr_i    (p0_addr),
      .wdata_i   (p0_wdata),
      .wmask_i   (p0_wmask),
      .rstrb_i   (p0_rstrb),
      .clear_i   (clear[PORT_CPU]),
      .pending_o (pend[PORT_CPU]),
      .is_read_o (is_rd[PORT_CPU]),
      .oor_o     (oor[PORT_CPU]),
      .addr_o    (s_addr[PORT_CPU]),
      .wdata_o   (s_wdata[PORT_CPU]),
      .wmask_o   (s_wmask[PORT_CPU]),
      .rbusy_o   (p0_rbusy),
      .wbusy_o   (p0_wbusy)
   );

   arb_req_slot #(.AW(AW)) u_slot_dbg (
      .clk       (clk),
      .rst       (rst),
      .addr_i    (p1_addr),
      .wdata_i   (p1_wdata),
      .wmask_i   (p1_wmask),
      .rstrb_i   (p1_rstrb),
      .clear_i   (clear[PORT_DBG]),
      .pending_o (pend[PORT_DBG]),
      .is_read_o (is_rd[PORT_DBG]),
      .oor_o     (oor[PORT_DBG]),
      .addr_o    (s_addr[PORT_DBG]),
      .wdata_o   (s_wdata[PORT_DBG]),
      .wmask_o   (s_wmask[PORT_DBG]),
      .rbusy_o   (p1_rbusy),
      .wbusy_o   (p1_wbusy)
   );

   arb_state_e        state_q,      state_d;
   logic              last_grant_q, last_grant_d;
   logic              ram_en_q,     ram_en_d;
   logic [MASK_W-1:0] ram_we_q,     ram_we_d;
   logic [AW-1:0]     ram_addr_q,   ram_addr_d;
   logic [BUS_W-1:0]  ram_wdata_q,  ram_wdata_d;
   logic [BUS_W-1:0]  rdata_q [2];
   logic [BUS_W-1:0]  rdata_d [2];
   logic [1:0]        rvalid_q,     rvalid_d;

   assign grant_pick = pick_port(pend[PORT_CPU], pend[PORT_DBG], last_grant_q);

   // last_grant_q doubles as the port owning the ACCESS/RDATA transaction.
   // NOTE: every always_comb output gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      ram_en_d     = 1'b0;
      ram_we_d     = '0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      rdata_d      = rdata_q;
      rvalid_d     = '0;
      clear        = '0;

      case (state_q)
         ARB_IDLE: begin
            if (|pend) begin
               last_grant_d = grant_pick;
               ram_en_d     = 1'b1;
               ram_addr_d   = s_addr[grant_pick];
               ram_wdata_d  = s_wdata[grant_pick];
               ram_we_d     = (is_rd[grant_pick] || oor[grant_pick]) ? '0 : s_wmask[grant_pick];
               state_d      = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            if (is_rd[last_grant_q]) begin
               state_d = ARB_RDATA;
            end else begin
               clear[last_grant_q] = 1'b1;
               state_d             = ARB_IDLE;
            end
         end
         ARB_RDATA: begin
            clear[last_grant_q]    = 1'b1;
            rvalid_d[last_grant_q] = 1'b1;
            rdata_d[last_grant_q]  = oor[last_grant_q] ? '0 : ram_rdata;
            state_d                = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= PORT_DBG;
         ram_en_q     <= 1'b0;
         ram_we_q     <= '0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         rdata_q[0]   <= '0;
         rdata_q[1]   <= '0;
         rvalid_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         rdata_q      <= rdata_d;
         rvalid_q     <= rvalid_d;
      end
   end

   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign p0_rdata  = rdata_q[PORT_CPU];
   assign p1_rdata  = rdata_q[PORT_DBG];
   assign p0_rvalid = rvalid_q[PORT_CPU];
   assign p1_rvalid = rvalid_q[PORT_DBG];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency RAM model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
   logic [3:0]  p0_wmask = '0, p1_wmask = '0;
   logic        p0_rstrb = 1'b0, p1_rstrb = 1'b0;
   logic [31:0] p0_rdata, p1_rdata;
   logic        p0_rvalid, p0_rbusy, p0_wbusy, p1_rvalid, p1_rbusy, p1_wbusy;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic [31:0] mem [DEPTH];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask), .p0_rstrb(p0_rstrb),
      .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid), .p0_rbusy(p0_rbusy), .p0_wbusy(p0_wbusy),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask), .p1_rstrb(p1_rstrb),
      .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid), .p1_rbusy(p1_rbusy), .p1_wbusy(p1_wbusy),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // Synchronous single-port RAM, read data valid the cycle after ram_en.
   always @(posedge clk) begin
      if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
         if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive_req(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wmask, input logic rstrb);
      if (port == PORT_CPU) begin
         p0_addr = addr; p0_wdata = wdata; p0_wmask = wmask; p0_rstrb = rstrb;
      end else begin
         p1_addr = addr; p1_wdata = wdata; p1_wmask = wmask; p1_rstrb = rstrb;
      end
   endtask

   task automatic drop_req();
      p0_wmask = '0; p0_rstrb = 1'b0; p1_wmask = '0; p1_rstrb = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   // Returns in the rvalid cycle, when the port is free to re-request.
   task automatic do_read(input logic port, input logic [31:0] addr, input logic [31:0] exp,
                          input string name);
      int   waited;
      logic rv;
      drive_req(port, addr, '0, 4'b0000, 1'b1);
      tick();
      drop_req();
      waited = 0;
      rv = (port == PORT_CPU) ? p0_rvalid : p1_rvalid;
      while (!rv && waited < 10) begin
         tick();
         waited++;
         rv = (port == PORT_CPU) ? p0_rvalid : p1_rvalid;
      end
      if (!rv) check({name, "_timeout"}, 32'(rv), 32'd1);
      else     check(name, (port == PORT_CPU) ? p0_rdata : p1_rdata, exp);
   endtask

   task automatic do_write(input logic port, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input string name);
      int   waited;
      logic wb;
      drive_req(port, addr, wdata, wmask, 1'b0);
      tick();
      drop_req();
      waited = 0;
      wb = (port == PORT_CPU) ? p0_wbusy : p1_wbusy;
      while (wb && waited < 10) begin
         tick();
         waited++;
         wb = (port == PORT_CPU) ? p0_wbusy : p1_wbusy;
      end
      check({name, "_done"}, 32'(wb), 32'd0);
   endtask

   typedef struct {
      logic        wr;
      logic        port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_en, n_rv, t0, t1;

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      mem[0] = 32'hA5A5A5A5;
      mem[5] = 32'hDEADBEEF;

      vecs[0] = '{wr:1'b1, port:1'b0, addr:32'h40,       wdata:32'h11223344, wmask:4'hF, exp:32'h0};
      vecs[1] = '{wr:1'b0, port:1'b1, addr:32'h40,       wdata:32'h0,        wmask:4'h0, exp:32'h11223344};
      vecs[2] = '{wr:1'b1, port:1'b1, addr:32'h41,       wdata:32'h0000AA00, wmask:4'h2, exp:32'h0};
      vecs[3] = '{wr:1'b0, port:1'b0, addr:32'h43,       wdata:32'h0,        wmask:4'h0, exp:32'h1122AA44};
      vecs[4] = '{wr:1'b1, port:1'b0, addr:32'hFFC,      wdata:32'hCAFEF00D, wmask:4'hF, exp:32'h0};
      vecs[5] = '{wr:1'b0, port:1'b1, addr:32'hFFC,      wdata:32'h0,        wmask:4'h0, exp:32'hCAFEF00D};
      vecs[6] = '{wr:1'b0, port:1'b0, addr:32'h0,        wdata:32'h0,        wmask:4'h0, exp:32'hA5A5A5A5};
      vecs[7] = '{wr:1'b1, port:1'b1, addr:32'h24,       wdata:32'h12345678, wmask:4'h9, exp:32'h0};
      vecs[8] = '{wr:1'b0, port:1'b0, addr:32'h24,       wdata:32'h0,        wmask:4'h0, exp:32'h12000078};
      vecs[9] = '{wr:1'b0, port:1'b1, addr:32'h80000000, wdata:32'h0,        wmask:4'h0, exp:32'h0};

      // Reset state
      tick();
      check("rst_p0_rdata", p0_rdata, 32'h0);
      check("rst_flags", {p0_rvalid, p0_rbusy, p0_wbusy, p1_rvalid, p1_rbusy, p1_wbusy, ram_en}, 32'h0);
      check("rst_ram_bus", {ram_we, 18'(ram_addr), 10'(ram_wdata)}, 32'h0);
      do_reset();

      // Single read, cycle by cycle: request presented in cycle C
      drive_req(PORT_CPU, 32'h14, '0, 4'b0000, 1'b1);
      tick();
      drop_req();
      check("rd_c1_busy", {p0_rbusy, ram_en}, 32'b10);
      tick();
      check("rd_c2_access", {p0_rbusy, ram_en, ram_we}, 32'b1_1_0000);
      check("rd_c2_addr", 32'(ram_addr), 32'd5);
      tick();
      check("rd_c3_rdata_state", {p0_rbusy, ram_en, p0_rvalid}, 32'b100);
      tick();
      check("rd_c4_valid", {p0_rbusy, p0_rvalid}, 32'b01);
      check("rd_c4_data", p0_rdata, 32'hDEADBEEF);
      tick();
      check("rd_c5_hold", {31'(p0_rvalid), 1'b0} | {1'b0, 31'(p0_rdata == 32'hDEADBEEF)}, 32'd1);

      // Byte write on port 1
      drive_req(PORT_DBG, 32'h22, 32'h00AB0000, 4'b0100, 1'b0);
      tick();
      drop_req();
      check("bw_c1_busy", {p1_wbusy, p1_rbusy, ram_en}, 32'b100);
      tick();
      check("bw_c2_access", {p1_wbusy, ram_en, ram_we}, 32'b1_1_0100);
      check("bw_c2_addr", 32'(ram_addr), 32'd8);
      check("bw_c2_wdata", ram_wdata, 32'h00AB0000);
      tick();
      check("bw_c3_idle", {p1_wbusy, ram_en, ram_we}, 32'h0);
      do_read(PORT_CPU, 32'h20, 32'h00AB0000, "bw_readback");

      // Strobe while busy is dropped, not queued
      n_en = 0; n_rv = 0;
      drive_req(PORT_CPU, 32'h14, '0, 4'b0000, 1'b1);
      tick();
      drop_req();
      for (int i = 0; i < 12; i++) begin
         if (ram_en) n_en++;
         if (p0_rvalid) n_rv++;
         if (i == 1) drive_req(PORT_CPU, 32'h0, '0, 4'b0000, 1'b1);
         else        p0_rstrb = 1'b0;
         tick();
      end
      check("ign_ram_accesses", 32'(n_en), 32'd1);
      check("ign_rvalids", 32'(n_rv), 32'd1);
      check("ign_rdata", p0_rdata, 32'hDEADBEEF);

      // Out-of-range write then read
      drive_req(PORT_CPU, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0);
      tick();
      drop_req();
      check("oor_c1_busy", 32'(p0_wbusy), 32'd1);
      tick();
      check("oor_c2_access", {ram_en, ram_we}, 32'b1_0000);
      check("oor_c2_addr", 32'(ram_addr), 32'd0);
      tick();
      check("oor_c3_done", 32'(p0_wbusy), 32'd0);
      do_read(PORT_CPU, 32'h1000, 32'h0, "oor_read");
      do_read(PORT_DBG, 32'h0, 32'hA5A5A5A5, "oor_ram0_kept");

      // Table of back-to-back transactions
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wr)
            do_write(vecs[i].port, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, $sformatf("vec%0d", i));
         else
            do_read(vecs[i].port, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Contention after reset: port 0 wins, port 1 rvalid three cycles later
      do_reset();
      drive_req(PORT_CPU, 32'h14, '0, 4'b0000, 1'b1);
      drive_req(PORT_DBG, 32'h0, '0, 4'b0000, 1'b1);
      tick();
      drop_req();
      t0 = -1; t1 = -1;
      for (int i = 1; i <= 12; i++) begin
         if (p0_rvalid && t0 < 0) t0 = i;
         if (p1_rvalid && t1 < 0) t1 = i;
         tick();
      end
      check("cont1_p0_cycle", 32'(t0), 32'd4);
      check("cont1_p1_cycle", 32'(t1), 32'd7);
      check("cont1_p0_data", p0_rdata, 32'hDEADBEEF);
      check("cont1_p1_data", p1_rdata, 32'hA5A5A5A5);

      // After a port-0 grant, the next tie goes to port 1
      do_read(PORT_CPU, 32'h0, 32'hA5A5A5A5, "cont_mid_read");
      drive_req(PORT_CPU, 32'h20, '0, 4'b0000, 1'b1);
      drive_req(PORT_DBG, 32'h14, '0, 4'b0000, 1'b1);
      tick();
      drop_req();
      t0 = -1; t1 = -1;
      for (int i = 1; i <= 12; i++) begin
         if (p0_rvalid && t0 < 0) t0 = i;
         if (p1_rvalid && t1 < 0) t1 = i;
         tick();
      end
      check("cont2_p1_cycle", 32'(t1), 32'd4);
      check("cont2_p0_cycle", 32'(t0), 32'd7);
      check("cont2_p1_data", p1_rdata, 32'hDEADBEEF);
      check("cont2_p0_data", p0_rdata, 32'h00AB0000);

      // Reset asserted during RDATA
      drive_req(PORT_CPU, 32'h14, '0, 4'b0000, 1'b1);
      tick();
      drop_req();
      tick();
      tick();
      check("mid_rst_pre_busy", 32'(p0_rbusy), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_flags", {p0_rbusy, p0_rvalid, p1_rbusy, ram_en}, 32'h0);
      check("mid_rst_p0_rdata", p0_rdata, 32'h0);
      check("mid_rst_p1_rdata", p1_rdata, 32'h0);
      check("mid_rst_ram_addr", 32'(ram_addr), 32'h0);
      tick();
      rst = 1'b0;
      n_rv = 0;
      for (int i = 0; i < 6; i++) begin
         if (p0_rvalid) n_rv++;
         tick();
      end
      check("mid_rst_no_rvalid", 32'(n_rv), 32'd0);
      drive_req(PORT_DBG, 32'h20, '0, 4'b0000, 1'b1);
      tick();
      drop_req();
      t1 = -1;
      for (int i = 1; i <= 10; i++) begin
         if (p1_rvalid && t1 < 0) t1 = i;
         tick();
      end
      check("post_rst_p1_cycle", 32'(t1), 32'd4);
      check("post_rst_p1_data", p1_rdata, 32'h00AB0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
